// File: rtl/vga_text_pkg.sv
// Shared text-mode character memory definitions: geometry defaults, command
// encodings, controller states and cursor helpers.
package vga_text_pkg;
   localparam int         COLS_DEF = 80;
   localparam int         ROWS_DEF = 30;
   localparam logic [7:0] FILL_DEF = 8'h20;
   localparam logic [7:0] NL_CHAR  = 8'h0A;

   typedef enum logic [1:0] {
      OP_SETPOS  = 2'd0,
      OP_HOME    = 2'd1,
      OP_CLEAR   = 2'd2,
      OP_NEWLINE = 2'd3
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_CLEAR = 2'd2
   } state_e;

   typedef struct packed {
      logic [4:0] row;
      logic [6:0] col;
   } cursor_t;

   function automatic cursor_t next_line(cursor_t c, logic [4:0] row_max);
      cursor_t n;
      n.col = '0;
      n.row = (c.row == row_max) ? 5'd0 : c.row + 5'd1;
      return n;
   endfunction

   // Step one cell right, spilling into the next row and wrapping the screen.
   function automatic cursor_t advance(cursor_t c, logic [6:0] col_max, logic [4:0] row_max);
      cursor_t n;
      if (c.col == col_max) n = next_line(c, row_max);
      else begin
         n.col = c.col + 7'd1;
         n.row = c.row;
      end
      return n;
   endfunction
endpackage

// File: rtl/cursor_addr.sv
// Linear character address from cursor position: row*COLS + col, built as a
// shift-add over the set bits of COLS so no multiplier is inferred.
module cursor_addr #(
   parameter int COLS = 80
) (
   input  logic [4:0]  row,
   input  logic [6:0]  col,
   output logic [11:0] addr
);
   localparam logic [11:0] COLS_W = 12'(COLS);

   always_comb begin
      addr = {5'd0, col};
      for (int i = 0; i < 12; i++)
         if (COLS_W[i]) addr = addr + ({7'd0, row} << i);
   end
endmodule

// File: rtl/charmem_ctrl.sv
// Character RAM controller: arbitrates one single-port RAM between display
// fetch (always wins) and host writes / commands that move a text cursor.
module charmem_ctrl
   import vga_text_pkg::*;
#(
   parameter int         COLS = COLS_DEF,
   parameter int         ROWS = ROWS_DEF,
   parameter logic [7:0] FILL = FILL_DEF
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        disp_req,
   input  logic [11:0] disp_addr,
   output logic [7:0]  disp_rdata,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [7:0]  wr_char,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [6:0]  cmd_col,
   input  logic [4:0]  cmd_row,
   output logic [11:0] ram_addr,
   output logic        ram_we,
   output logic [7:0]  ram_wdata,
   input  logic [7:0]  ram_rdata,
   output logic [6:0]  cur_col,
   output logic [4:0]  cur_row,
   output logic        busy
);
   localparam logic [6:0]  COL_MAX   = 7'(COLS - 1);
   localparam logic [4:0]  ROW_MAX   = 5'(ROWS - 1);
   localparam logic [11:0] LAST_ADDR = 12'(COLS * ROWS - 1);

   state_e      state;
   cursor_t     cur;
   logic [11:0] clr_cnt;
   logic [7:0]  chr;
   logic [11:0] cur_addr;

   cursor_addr #(.COLS(COLS)) u_addr (
      .row  (cur.row),
      .col  (cur.col),
      .addr (cur_addr)
   );

   assign disp_rdata = ram_rdata;
   assign cur_col    = cur.col;
   assign cur_row    = cur.row;
   assign cmd_ready  = clr_n && (state == ST_IDLE);
   assign wr_ready   = cmd_ready && !cmd_valid;
   assign busy       = clr_n && (state != ST_IDLE);

   // RAM port is combinational so display fetch can preempt in the same cycle.
   always_comb begin
      ram_addr  = disp_addr;
      ram_we    = 1'b0;
      ram_wdata = chr;
      if (!disp_req) begin
         case (state)
            ST_WRITE: begin
               ram_addr = cur_addr;
               ram_we   = clr_n;
            end
            ST_CLEAR: begin
               ram_addr  = clr_cnt;
               ram_we    = clr_n;
               ram_wdata = FILL;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state   <= ST_IDLE;
         cur     <= '0;
         clr_cnt <= '0;
         chr     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  case (cmd_op_e'(cmd_op))
                     OP_SETPOS: begin
                        cur.col <= (cmd_col > COL_MAX) ? COL_MAX : cmd_col;
                        cur.row <= (cmd_row > ROW_MAX) ? ROW_MAX : cmd_row;
                     end
                     OP_HOME:    cur   <= '0;
                     OP_CLEAR:   begin
                        clr_cnt <= '0;
                        state   <= ST_CLEAR;
                     end
                     OP_NEWLINE: cur   <= next_line(cur, ROW_MAX);
                     default:    ;
                  endcase
               end else if (wr_valid) begin
                  if (wr_char == NL_CHAR) cur <= next_line(cur, ROW_MAX);
                  else begin
                     chr   <= wr_char;
                     state <= ST_WRITE;
                  end
               end
            end
            ST_WRITE: begin
               if (!disp_req) begin
                  cur   <= advance(cur, COL_MAX, ROW_MAX);
                  state <= ST_IDLE;
               end
            end
            ST_CLEAR: begin
               if (!disp_req) begin
                  if (clr_cnt == LAST_ADDR) begin
                     clr_cnt <= '0;
                     cur     <= '0;
                     state   <= ST_IDLE;
                  end else begin
                     clr_cnt <= clr_cnt + 12'd1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_charmem_ctrl.sv
// Self-checking bench for charmem_ctrl: directed scenarios plus a randomized
// op stream compared against a linear-index screen model.
module tb_charmem_ctrl;
   localparam int COLS = 80;
   localparam int ROWS = 30;
   localparam int CELLS = COLS * ROWS;

   logic        clk = 0;
   logic        clr_n, disp_req, wr_valid, cmd_valid;
   logic [11:0] disp_addr;
   logic [7:0]  wr_char;
   logic [1:0]  cmd_op;
   logic [6:0]  cmd_col;
   logic [4:0]  cmd_row;
   logic [7:0]  disp_rdata, ram_wdata, ram_rdata;
   logic        wr_ready, cmd_ready, ram_we, busy;
   logic [11:0] ram_addr;
   logic [6:0]  cur_col;
   logic [4:0]  cur_row;

   charmem_ctrl #(.COLS(COLS), .ROWS(ROWS), .FILL(8'h20)) dut (
      .clk(clk), .clr_n(clr_n), .disp_req(disp_req), .disp_addr(disp_addr),
      .disp_rdata(disp_rdata), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_char(wr_char), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_col(cmd_col), .cmd_row(cmd_row),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
   );

   always #5 clk = ~clk;

   // RAM model with 1-cycle read latency, plus a log of every write.
   logic [7:0]  mem [0:4095];
   logic [19:0] wlog [$];
   int          viol = 0;
   always @(posedge clk) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
         wlog.push_back({ram_addr, ram_wdata});
         if (disp_req) viol++;
      end
   end

   // Reference model: screen as a flat array, cursor as a linear cell index.
   logic [7:0] exp_mem [0:CELLS-1];
   int exp_col = 0, exp_row = 0;
   int n_chk = 0, n_fail = 0;

   function automatic void m_nl();
      exp_col = 0;
      exp_row = (exp_row + 1) % ROWS;
   endfunction

   function automatic void m_wr(input logic [7:0] c);
      int idx;
      if (c == 8'h0A) begin m_nl(); return; end
      idx = exp_row * COLS + exp_col;
      exp_mem[idx] = c;
      idx = (idx + 1) % CELLS;
      exp_row = idx / COLS;
      exp_col = idx % COLS;
   endfunction

   function automatic void m_cmd(input int op, input int c, input int r);
      case (op)
         0: begin exp_col = (c > COLS-1) ? COLS-1 : c; exp_row = (r > ROWS-1) ? ROWS-1 : r; end
         1: begin exp_col = 0; exp_row = 0; end
         2: begin for (int i = 0; i < CELLS; i++) exp_mem[i] = 8'h20; exp_col = 0; exp_row = 0; end
         default: m_nl();
      endcase
   endfunction

   // Drivers assume they are entered just after a negedge with the DUT idle.
   task automatic send_wr(input logic [7:0] c);
      wr_valid = 1; wr_char = c;
      @(negedge clk);
      wr_valid = 0;
      m_wr(c);
   endtask

   task automatic send_cmd(input int op, input int c, input int r);
      cmd_valid = 1; cmd_op = 2'(op); cmd_col = 7'(c); cmd_row = 5'(r);
      @(negedge clk);
      cmd_valid = 0;
      m_cmd(op, c, r);
   endtask

   task automatic wait_idle(input bit rand_disp, input int limit);
      int t = 0;
      while (busy && t < limit) begin
         if (rand_disp) begin disp_req = 1'($urandom); disp_addr = 12'($urandom_range(0, 4095)); end
         @(negedge clk); t++;
      end
      disp_req = 0;
      n_chk++;
      if (busy) begin n_fail++; $display("FAIL wait_idle: busy=%0b after %0d cycles, want 0", busy, t); end
   endtask

   task automatic test_reset();
      clr_n = 0; disp_req = 1; disp_addr = 12'd123;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({wr_ready, cmd_ready, ram_we, busy} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_outputs: got %b want 0000", {wr_ready, cmd_ready, ram_we, busy});
      end
      n_chk++;
      if (ram_addr !== 12'd123) begin n_fail++; $display("FAIL reset_disp_addr: got %0d want 123", ram_addr); end
      n_chk++;
      if (disp_rdata !== mem[123]) begin n_fail++; $display("FAIL reset_disp_rdata: got %h want %h", disp_rdata, mem[123]); end
      disp_req = 0; clr_n = 1;
      @(negedge clk);
      n_chk++;
      if ({cur_col, cur_row, busy, wr_ready, cmd_ready} !== {7'd0, 5'd0, 3'b011}) begin
         n_fail++; $display("FAIL reset_state: got col %0d row %0d busy %0b wr_rdy %0b cmd_rdy %0b want 0 0 0 1 1",
                            cur_col, cur_row, busy, wr_ready, cmd_ready);
      end
      exp_col = 0; exp_row = 0;
   endtask

   task automatic test_write_basic();
      wlog.delete();
      send_wr(8'h41);
      wait_idle(0, 20);
      n_chk++;
      if (wlog.size() != 1 || wlog[0] !== {12'd0, 8'h41}) begin
         n_fail++; $display("FAIL write_basic_log: got %0d writes first %h want 1 write 00041", wlog.size(), wlog.size() ? wlog[0] : 20'h0);
      end
      n_chk++;
      if (cur_col !== 7'd1 || cur_row !== 5'd0) begin
         n_fail++; $display("FAIL write_basic_cursor: got (%0d,%0d) want (1,0)", cur_col, cur_row);
      end
   endtask

   task automatic test_wrap();
      send_cmd(0, 79, 29);
      wlog.delete();
      send_wr(8'h42);
      wait_idle(0, 20);
      n_chk++;
      if (wlog.size() != 1 || wlog[0] !== {12'd2399, 8'h42}) begin
         n_fail++; $display("FAIL wrap_log: got %0d writes first %h want 1 write %h", wlog.size(), wlog.size() ? wlog[0] : 20'h0, {12'd2399, 8'h42});
      end
      n_chk++;
      if (cur_col !== 7'(exp_col) || cur_row !== 5'(exp_row) || exp_col != 0 || exp_row != 0) begin
         n_fail++; $display("FAIL wrap_cursor: got (%0d,%0d) want (0,0)", cur_col, cur_row);
      end
   endtask

   task automatic test_disp_stall();
      logic [11:0] a;
      int bad = 0;
      send_cmd(0, 5, 3);
      wlog.delete();
      a = 12'($urandom_range(0, 4095));
      wr_valid = 1; wr_char = 8'h5A; disp_req = 1; disp_addr = a;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         wr_valid = 0;
         if (ram_we !== 1'b0 || ram_addr !== a || busy !== 1'b1) bad++;
         if (i > 0 && disp_rdata !== mem[a]) bad++;
      end
      m_wr(8'h5A);
      n_chk++;
      if (bad != 0 || wlog.size() != 0) begin
         n_fail++; $display("FAIL stall_hold: got %0d bad cycles %0d writes want 0 0", bad, wlog.size());
      end
      disp_req = 0;
      #1;
      n_chk++;
      if (ram_we !== 1'b1 || ram_addr !== 12'(3*COLS+5) || ram_wdata !== 8'h5A) begin
         n_fail++; $display("FAIL stall_release: got we %0b addr %0d data %h want 1 %0d 5a", ram_we, ram_addr, ram_wdata, 3*COLS+5);
      end
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || wlog.size() != 1 || cur_col !== 7'(exp_col) || cur_row !== 5'(exp_row)) begin
         n_fail++; $display("FAIL stall_after: got busy %0b writes %0d cursor (%0d,%0d) want 0 1 (%0d,%0d)",
                            busy, wlog.size(), cur_col, cur_row, exp_col, exp_row);
      end
   endtask

   task automatic test_clear();
      int bad = 0;
      wlog.delete(); viol = 0;
      send_cmd(2, 0, 0);
      wait_idle(1, 10000);
      for (int i = 0; i < wlog.size(); i++)
         if (wlog[i] !== {12'(i), 8'h20}) bad++;
      n_chk++;
      if (wlog.size() != CELLS || bad != 0) begin
         n_fail++; $display("FAIL clear_log: got %0d writes %0d out of order want %0d 0", wlog.size(), bad, CELLS);
      end
      n_chk++;
      if (viol != 0) begin n_fail++; $display("FAIL clear_disp_prio: got %0d writes under disp_req want 0", viol); end
      n_chk++;
      if (cur_col !== 7'd0 || cur_row !== 5'd0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL clear_end: got (%0d,%0d) busy %0b want (0,0) 0", cur_col, cur_row, busy);
      end
   endtask

   task automatic test_collision();
      wlog.delete();
      cmd_valid = 1; cmd_op = 2'd0; cmd_col = 7'd120; cmd_row = 5'd31;
      wr_valid = 1; wr_char = 8'h5A;
      #1;
      n_chk++;
      if (wr_ready !== 1'b0 || cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL collide_ready: got wr %0b cmd %0b want 0 1", wr_ready, cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 0; wr_valid = 0;
      m_cmd(0, 120, 31);
      @(negedge clk);
      n_chk++;
      if (cur_col !== 7'd79 || cur_row !== 5'd29 || busy !== 1'b0 || wlog.size() != 0) begin
         n_fail++; $display("FAIL collide_result: got (%0d,%0d) busy %0b writes %0d want (79,29) 0 0",
                            cur_col, cur_row, busy, wlog.size());
      end
   endtask

   task automatic test_reset_mid_clear();
      int t = 0;
      int n0;
      send_cmd(2, 0, 0);
      wlog.delete();
      while (!(ram_we && ram_addr == 12'd1000) && t < 3000) begin @(negedge clk); t++; end
      clr_n = 0;
      #1;
      n0 = wlog.size();
      n_chk++;
      if (ram_we !== 1'b0 || n0 != 1000) begin
         n_fail++; $display("FAIL midclr_abort: got we %0b writes %0d want 0 1000", ram_we, n0);
      end
      repeat (3) @(negedge clk);
      clr_n = 1;
      #1;
      n_chk++;
      if (cmd_ready !== 1'b1 || wr_ready !== 1'b1 || busy !== 1'b0 || cur_col !== 7'd0 || cur_row !== 5'd0) begin
         n_fail++; $display("FAIL midclr_state: got rdy %0b%0b busy %0b cursor (%0d,%0d) want 11 0 (0,0)",
                            cmd_ready, wr_ready, busy, cur_col, cur_row);
      end
      repeat (5) @(negedge clk);
      n_chk++;
      if (wlog.size() != n0) begin n_fail++; $display("FAIL midclr_quiet: got %0d writes want %0d", wlog.size(), n0); end
      exp_col = 0; exp_row = 0;
   endtask

   task automatic test_random();
      int bad = 0, cbad = 0;
      send_cmd(2, 0, 0);
      wait_idle(1, 10000);
      for (int k = 0; k < 150; k++) begin
         int r = $urandom_range(0, 99);
         if (r < 65) send_wr(($urandom_range(0, 9) == 0) ? 8'h0A : 8'($urandom_range(8'h21, 8'h7E)));
         else if (r < 85) send_cmd(0, $urandom_range(0, 127), $urandom_range(0, 31));
         else if (r < 92) send_cmd(1, 0, 0);
         else send_cmd(3, 0, 0);
         wait_idle(1, 200);
         if (cur_col !== 7'(exp_col) || cur_row !== 5'(exp_row)) cbad++;
      end
      @(negedge clk);
      n_chk++;
      if (cbad != 0) begin n_fail++; $display("FAIL random_cursor: got %0d cursor errors want 0", cbad); end
      for (int i = 0; i < CELLS; i++) if (mem[i] !== exp_mem[i]) bad++;
      n_chk++;
      if (bad != 0) begin n_fail++; $display("FAIL random_screen: got %0d cells differ want 0", bad); end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      wr_valid = 0; cmd_valid = 0; wr_char = 0; cmd_op = 0; cmd_col = 0; cmd_row = 0;
      disp_req = 0; disp_addr = 0; clr_n = 0;
      @(negedge clk);
      test_reset();
      test_write_basic();
      test_wrap();
      test_disp_stall();
      test_clear();
      test_collision();
      test_reset_mid_clear();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end
endmodule
